// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants for the multiplexed BCD/hex display counter: segment codes, blank code,
// digit maxima and the decoded key operation.
package bcd_scan_counter_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment codes, entry n is the glyph for nibble n; bit 7 (dp) stays high.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {OpNone, OpClr, OpUp, OpDown} op_e;

  function automatic logic [3:0] digit_max(input bit hex_mode);
    return hex_mode ? 4'd15 : 4'd9;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Key inputs and display/count outputs of the scan counter, bundled for the top-level port.
interface bcd_scan_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  btn_up;
  logic                  btn_down;
  logic                  btn_clr;
  logic [DIGITS-1:0]     digit;
  logic [7:0]            segment;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;

  modport master (
    output btn_up, btn_down, btn_clr,
    input  digit, segment, count, wrap
  );

  modport slave (
    input  btn_up, btn_down, btn_clr,
    output digit, segment, count, wrap
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability-count debouncer and single-cycle press detector for one key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  // The press pulse is taken from the registered accepted level, adding one stage of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= key_i;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Debounced up/down/clear BCD or hex counter driving a time-multiplexed active-low 7-seg display.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 2500000,
  parameter int unsigned SCAN_CYCLES     = 12500,
  parameter int unsigned HEX_MODE        = 0,
  parameter int unsigned BLANK_LZ        = 0
) (
  input logic               clk,
  input logic               reset,
  bcd_scan_counter_if.slave bus
);
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ScanW = $clog2(SCAN_CYCLES);
  localparam logic [3:0]  DMax  = digit_max(HEX_MODE != 0);

  logic up_p, down_p, clr_p;
  op_e  op;

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]   digit_q, digit_d;
  logic [7:0]          segment_q, segment_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk(clk), .reset(reset), .key_i(bus.btn_up), .press_o(up_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
    .clk(clk), .reset(reset), .key_i(bus.btn_down), .press_o(down_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk(clk), .reset(reset), .key_i(bus.btn_clr), .press_o(clr_p)
  );

  always_comb begin
    op = OpNone;
    if (clr_p)                op = OpClr;
    else if (up_p ^ down_p)   op = up_p ? OpUp : OpDown;
  end

  // Ripple carry/borrow through the nibbles; a carry out of the top digit is a wrap.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    count_d = count_q;
    wrap_d  = 1'b0;
    nib     = '0;
    carry   = 1'b1;
    unique case (op)
      OpClr: count_d = '0;
      OpUp: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          nib = count_q[4*i +: 4];
          if (carry) begin
            if (nib == DMax) nib = '0;
            else begin
              nib   = nib + 4'd1;
              carry = 1'b0;
            end
          end
          count_d[4*i +: 4] = nib;
        end
        wrap_d = carry;
      end
      OpDown: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          nib = count_q[4*i +: 4];
          if (carry) begin
            if (nib == 4'd0) nib = DMax;
            else begin
              nib   = nib - 4'd1;
              carry = 1'b0;
            end
          end
          count_d[4*i +: 4] = nib;
        end
        wrap_d = carry;
      end
      default: ;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == ScanW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Digit and segment are both built from idx_q so a frame never mixes two digits.
  always_comb begin
    logic [DIGITS-1:0] blank;
    logic              zero_above;
    logic [3:0]        sel_nib;
    logic              sel_blank;
    blank      = '0;
    zero_above = (BLANK_LZ != 0);
    sel_nib    = '0;
    sel_blank  = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib   = count_q[4*i +: 4];
        sel_blank = blank[i];
      end
    end
    digit_d   = ~(DIGITS'(1) << idx_q);
    segment_d = sel_blank ? SEG_BLANK : SEG_TABLE[sel_nib];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      digit_q    <= '1;
      segment_q  <= SEG_BLANK;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      segment_q  <= segment_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.digit   = digit_q;
  assign bus.segment = segment_q;

endmodule
